pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Pipeline sequencer for the 5-stage RV32 core. Detects load-use hazards, branch-taken flushes and data-memory
//  wait states. Drives per-stage write enables, flushes and control_path's control_sel (bubble select).
//  Sits beside control_path in ID. Observes the ID, EX and MEM pipeline registers.
// PARAMETERS
//  MEM_TIMEOUT  16  max consecutive dmem wait cycles before sticky error
//  CNT_W        16  width of saturating performance counters
// PORTS
//  clk              in   1      core clock, all state on rising edge
//  rst_n            in   1      asynchronous, active-low reset
//  id_opcode        in   7      opcode of instruction in IF/ID
//  id_rs1           in   5      rs1 field in IF/ID
//  id_rs2           in   5      rs2 field in IF/ID
//  ex_rd            in   5      rd in ID/EX
//  ex_mem_read      in   1      MemRead in ID/EX
//  ex_branch_taken  in   1      branch resolved taken in EX
//  mem_req          in   1      MemRead|MemWrite in EX/MEM
//  mem_ready        in   1      dmem completes access this cycle
//  pc_write         out  1      PC update enable
//  if_id_write      out  1      IF/ID load enable
//  id_ex_write      out  1      ID/EX load enable
//  ex_mem_write     out  1      EX/MEM load enable
//  mem_wb_write     out  1      MEM/WB load enable
//  control_sel      out  1      1 = control_path emits all-zero controls (bubble)
//  if_id_flush      out  1      clear IF/ID to nop (opcode 7'b0000000)
//  stall_cnt        out  CNT_W  saturating count of stall/freeze cycles
//  flush_cnt        out  CNT_W  saturating count of branch flushes
//  mem_timeout_err  out  1      sticky dmem timeout flag
// BEHAVIOUR
//  States: INIT, RUN, MEM_WAIT, ERROR. State is registered. Outputs are combinational from state and inputs.
//  Reset (rst_n=0):
//   - State goes to INIT. All *_write=0, control_sel=1, if_id_flush=0.
//   - Counters=0, mem_timeout_err=0.
//   - Reset mid-operation aborts any wait and clears wait_cnt.
//  INIT: outputs as in reset for exactly 1 cycle after release, then RUN.
//  uses_rs1: opcode in {0000011,0100011,0110011,0010011,1100011}.
//  uses_rs2: opcode in {0100011,0110011,1100011}.
//  lu_hz = ex_mem_read & ex_rd!=0 & ((uses_rs1 & ex_rd==id_rs1) | (uses_rs2 & ex_rd==id_rs2)).
//  freeze = mem_req & ~mem_ready.
//  Priority in RUN/MEM_WAIT: freeze > ex_branch_taken > lu_hz > normal.
//   - freeze: all five *_write=0, control_sel=0, if_id_flush=0. Branch and lu_hz are ignored; they are
//     re-evaluated when the pipe unfreezes, since EX is held. Enter/stay MEM_WAIT; wait_cnt+1.
//   - branch: all *_write=1, if_id_flush=1, control_sel=1 (ID/EX gets bubble). lu_hz is suppressed.
//     flush_cnt+1.
//   - lu_hz: pc_write=0, if_id_write=0, control_sel=1, rest=1. Single-cycle stall; the bubble in EX
//     clears the hazard next cycle.
//   - normal: all *_write=1, control_sel=0, if_id_flush=0.
//  MEM_WAIT -> RUN on the first cycle mem_ready=1 (that cycle is not a freeze); wait_cnt clears.
//  When freeze holds and wait_cnt==MEM_TIMEOUT-1: next state ERROR, mem_timeout_err<=1.
//  ERROR: outputs as freeze. Leaves only via rst_n.
//  stall_cnt +1 every cycle in RUN/MEM_WAIT with freeze or lu_hz. Both counters saturate at 2^CNT_W-1,
//  no wrap. INIT/ERROR cycles are not counted.
//  wait_cnt width is $clog2(MEM_TIMEOUT+1).
// STRUCTURE
//  riscv_pkg: opcode localparams (OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH, OP_NOP) shared with control_path.
//  riscv_pkg: FSM state encoding (2-bit).
//  Sub-module hazard_detect: purely combinational uses_rs1/uses_rs2 decode and lu_hz compare.
//  Top holds the FSM, wait counter, perf counters and output mux.
// TESTING
//  1. Reset release: INIT cycle has all *_write=0, control_sel=1. Next cycle, no hazards, all *_write=1.
//  2. Load-use: ex_mem_read=1, ex_rd=5, id_opcode=0110011, id_rs2=5 -> one cycle pc_write=0,
//     if_id_write=0, control_sel=1; stall_cnt=1.
//  3. x0 and no-use cases: ex_rd=0, or id_opcode=0010011 with only id_rs2 matching -> no stall.
//  4. Branch: ex_branch_taken=1 with lu_hz=1 -> if_id_flush=1, control_sel=1, pc_write=1; flush_cnt=1;
//     no stall.
//  5. Mem wait: mem_req=1, mem_ready=0 for 3 cycles then 1 -> all writes 0 for 3 cycles, RUN on
//     4th; stall_cnt=3.
//  6. Timeout: MEM_TIMEOUT=4 with mem_ready held 0 -> err=1 after 4 cycles, sticky. Async rst_n pulse
//     mid-wait clears err and counters immediately.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32 definitions: opcodes used by control_path and hazard logic,
// plus the pipeline sequencer state encoding.
package riscv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_NOP    = 7'b0000000;

  typedef enum logic [1:0] {
    ST_INIT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_ERROR    = 2'd3
  } hz_state_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection: decodes which source registers the ID
// instruction reads and compares them against a pending load in EX.
module hazard_detect
  import riscv_pkg::*;
(
  input  logic [6:0] id_opcode,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_mem_read,
  output logic       lu_hz
);

  logic uses_rs1;
  logic uses_rs2;

  // x0 is never a real producer, so a load targeting it cannot create a hazard
  always_comb begin
    uses_rs1 = id_opcode inside {OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH};
    uses_rs2 = id_opcode inside {OP_STORE, OP_R, OP_BRANCH};
    lu_hz    = ex_mem_read && (ex_rd != 5'd0) &&
               ((uses_rs1 && (ex_rd == id_rs1)) || (uses_rs2 && (ex_rd == id_rs2)));
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage RV32 core: stalls, flushes and freezes
// the pipe for load-use hazards, taken branches and data-memory wait states.
module pipeline_hazard_ctrl
  import riscv_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       id_opcode,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             ex_mem_write,
  output logic             mem_wb_write,
  output logic             control_sel,
  output logic             if_id_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_timeout_err
);

  localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  hz_state_t         state;
  hz_state_t         state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_cnt_nxt;
  logic              err_nxt;
  logic              stall_inc;
  logic              flush_inc;
  logic              lu_hz;
  logic              freeze;
  logic [4:0]        stage_write;

  hazard_detect u_hazard_detect (
    .id_opcode   (id_opcode),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .lu_hz       (lu_hz)
  );

  assign freeze = mem_req && !mem_ready;
  assign {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write} = stage_write;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_INIT;
      wait_cnt        <= '0;
      mem_timeout_err <= 1'b0;
      stall_cnt       <= '0;
      flush_cnt       <= '0;
    end else begin
      state           <= state_nxt;
      wait_cnt        <= wait_cnt_nxt;
      mem_timeout_err <= err_nxt;
      if (stall_inc && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + 1'b1;
      if (flush_inc && (flush_cnt != CNT_MAX)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

  // A frozen pipe holds EX, so branch and load-use decisions wait until it thaws
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    err_nxt      = mem_timeout_err;
    stage_write  = 5'b00000;
    control_sel  = 1'b1;
    if_id_flush  = 1'b0;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    case (state)
      ST_INIT: state_nxt = ST_RUN;
      ST_RUN, ST_MEM_WAIT: begin
        if (freeze) begin
          control_sel  = 1'b0;
          stall_inc    = 1'b1;
          wait_cnt_nxt = wait_cnt + 1'b1;
          if (wait_cnt == WAIT_LAST) begin
            state_nxt = ST_ERROR;
            err_nxt   = 1'b1;
          end else begin
            state_nxt = ST_MEM_WAIT;
          end
        end else begin
          state_nxt    = ST_RUN;
          wait_cnt_nxt = '0;
          if (ex_branch_taken) begin
            stage_write = 5'b11111;
            if_id_flush = 1'b1;
            flush_inc   = 1'b1;
          end else if (lu_hz) begin
            stage_write = 5'b00111;
            stall_inc   = 1'b1;
          end else begin
            stage_write = 5'b11111;
            control_sel = 1'b0;
          end
        end
      end
      ST_ERROR: control_sel = 1'b0;
      default:  state_nxt = ST_INIT;
    endcase
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus a
// randomized run, all compared against a behavioural sequencer model.
module tb_pipeline_hazard_ctrl;
  import riscv_pkg::*;

  localparam int TO = 4;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [6:0]    id_opcode = '0;
  logic [4:0]    id_rs1 = '0;
  logic [4:0]    id_rs2 = '0;
  logic [4:0]    ex_rd = '0;
  logic          ex_mem_read = 1'b0;
  logic          ex_branch_taken = 1'b0;
  logic          mem_req = 1'b0;
  logic          mem_ready = 1'b1;
  logic          pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write;
  logic          control_sel, if_id_flush, mem_timeout_err;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [15:0]   obs;

  int checks = 0;
  int passes = 0;

  // Model state: pending INIT cycle, sticky error, consecutive waits, counters
  bit m_init;
  bit m_err;
  int m_waits;
  int m_stall;
  int m_flush;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_opcode       (id_opcode),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .ex_rd           (ex_rd),
    .ex_mem_read     (ex_mem_read),
    .ex_branch_taken (ex_branch_taken),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .id_ex_write     (id_ex_write),
    .ex_mem_write    (ex_mem_write),
    .mem_wb_write    (mem_wb_write),
    .control_sel     (control_sel),
    .if_id_flush     (if_id_flush),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt),
    .mem_timeout_err (mem_timeout_err)
  );

  always #5 clk = ~clk;

  assign obs = {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
                control_sel, if_id_flush, stall_cnt, flush_cnt, mem_timeout_err};

  function automatic bit model_lu();
    bit r1, r2;
    r1 = id_opcode inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011};
    r2 = id_opcode inside {7'b0100011, 7'b0110011, 7'b1100011};
    return ex_mem_read && (ex_rd != 0) && ((r1 && ex_rd == id_rs1) || (r2 && ex_rd == id_rs2));
  endfunction

  // Control word order: pc, if_id, id_ex, ex_mem, mem_wb, control_sel, flush
  function automatic logic [6:0] model_ctl();
    if (!rst_n || m_init) return 7'b0000010;
    if (m_err || (mem_req && !mem_ready)) return 7'b0000000;
    if (ex_branch_taken) return 7'b1111111;
    if (model_lu()) return 7'b0011110;
    return 7'b1111100;
  endfunction

  function automatic logic [15:0] model_exp();
    return {model_ctl(), 4'(m_stall), 4'(m_flush), m_err};
  endfunction

  task automatic model_reset();
    m_init = 1; m_err = 0; m_waits = 0; m_stall = 0; m_flush = 0;
  endtask

  task automatic model_advance();
    if (!rst_n) model_reset();
    else if (m_err) begin end
    else if (m_init) m_init = 0;
    else if (mem_req && !mem_ready) begin
      m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
      if (m_waits == TO - 1) m_err = 1;
      m_waits++;
    end else begin
      m_waits = 0;
      if (ex_branch_taken) m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
      else if (model_lu()) m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
    end
  endtask

  task automatic drive(input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rd, input logic mr, input logic br,
                       input logic rq, input logic rdy);
    @(negedge clk);
    id_opcode = op; id_rs1 = r1; id_rs2 = r2; ex_rd = rd;
    ex_mem_read = mr; ex_branch_taken = br; mem_req = rq; mem_ready = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    model_advance();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    id_opcode = OP_NOP; id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
    ex_mem_read = 0; ex_branch_taken = 0; mem_req = 0; mem_ready = 1;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 0;
    model_reset();
    #1;
    checks++;
    if (obs !== model_exp() || obs !== 16'b0000010_0000_0000_0)
      $display("[TB] FAIL reset_hold: got %b expected %b", obs, 16'b0000010_0000_0000_0);
    else passes++;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    #1;
    checks++;
    if (obs !== model_exp() || obs[15:9] !== 7'b0000010)
      $display("[TB] FAIL init_cycle: got %b expected %b", obs[15:9], 7'b0000010);
    else passes++;
    tick();
    drive(OP_NOP, 0, 0, 0, 0, 0, 0, 1);
    #1;
    checks++;
    if (obs !== model_exp() || obs[15:9] !== 7'b1111100)
      $display("[TB] FAIL first_run: got %b expected %b", obs[15:9], 7'b1111100);
    else passes++;
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    tick();
    drive(OP_R, 1, 5, 5, 1, 0, 0, 1);
    #1;
    checks++;
    if (obs !== model_exp() || obs[15:9] !== 7'b0011110)
      $display("[TB] FAIL load_use: got %b expected %b", obs[15:9], 7'b0011110);
    else passes++;
    tick();
    drive(OP_R, 1, 5, 5, 0, 0, 0, 1);
    #1;
    checks++;
    if (obs !== model_exp() || obs[15:5] !== {7'b1111100, 4'd1})
      $display("[TB] FAIL load_use_after: got %b expected %b", obs[15:5], {7'b1111100, 4'd1});
    else passes++;
    tick();
  endtask

  task automatic test_no_use();
    logic [6:0] ops [4];
    logic [6:0] want [4];
    logic [4:0] rs1s [4];
    logic [4:0] rds [4];
    ops  = '{OP_R, OP_I, OP_STORE, OP_BRANCH};
    rs1s = '{5'd0, 5'd3, 5'd3, 5'd9};
    rds  = '{5'd0, 5'd7, 5'd7, 5'd9};
    want = '{7'b1111100, 7'b1111100, 7'b0011110, 7'b0011110};
    do_reset();
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(ops[i], rs1s[i], 5'd7, rds[i], 1, 0, 0, 1);
      #1;
      checks++;
      if (obs !== model_exp() || obs[15:9] !== want[i])
        $display("[TB] FAIL no_use_%0d: got %b expected %b", i, obs[15:9], want[i]);
      else passes++;
      tick();
    end
    drive(OP_NOP, 0, 0, 0, 0, 0, 0, 1);
    #1;
    checks++;
    if (obs !== model_exp() || obs[8:5] !== 4'd2)
      $display("[TB] FAIL no_use_stall_cnt: got %0d expected 2", obs[8:5]);
    else passes++;
    tick();
  endtask

  task automatic test_branch();
    do_reset();
    tick();
    drive(OP_R, 1, 5, 5, 1, 1, 0, 1);
    #1;
    checks++;
    if (obs !== model_exp() || obs[15:9] !== 7'b1111111)
      $display("[TB] FAIL branch: got %b expected %b", obs[15:9], 7'b1111111);
    else passes++;
    tick();
    drive(OP_NOP, 0, 0, 0, 0, 0, 0, 1);
    #1;
    checks++;
    if (obs !== model_exp() || obs[8:1] !== {4'd0, 4'd1})
      $display("[TB] FAIL branch_counts: got stall %0d flush %0d expected 0 1", obs[8:5], obs[4:1]);
    else passes++;
    tick();
  endtask

  task automatic test_mem_wait();
    do_reset();
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(OP_R, 1, 5, 5, 1, 1, 1, 0);
      #1;
      checks++;
      if (obs !== model_exp() || obs[15:9] !== 7'b0000000)
        $display("[TB] FAIL mem_wait_%0d: got %b expected %b", i, obs[15:9], 7'b0000000);
      else passes++;
      tick();
    end
    drive(OP_NOP, 0, 0, 0, 0, 0, 1, 1);
    #1;
    checks++;
    if (obs !== model_exp() || obs[15:9] !== 7'b1111100)
      $display("[TB] FAIL mem_wait_release: got %b expected %b", obs[15:9], 7'b1111100);
    else passes++;
    tick();
    drive(OP_NOP, 0, 0, 0, 0, 0, 0, 1);
    #1;
    checks++;
    if (obs !== model_exp() || obs[8:5] !== 4'd3 || obs[0] !== 1'b0)
      $display("[TB] FAIL mem_wait_counts: got stall %0d err %0d expected 3 0", obs[8:5], obs[0]);
    else passes++;
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    tick();
    for (int i = 0; i < TO; i++) begin
      drive(OP_NOP, 0, 0, 0, 0, 0, 1, 0);
      #1;
      checks++;
      if (obs !== model_exp() || obs[0] !== 1'b0)
        $display("[TB] FAIL timeout_pre_%0d: got err %0d expected 0", i, obs[0]);
      else passes++;
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(OP_NOP, 0, 0, 0, 0, 0, 0, 1);
      #1;
      checks++;
      if (obs !== model_exp() || obs[15:9] !== 7'b0000000 || obs[0] !== 1'b1)
        $display("[TB] FAIL timeout_sticky_%0d: got ctl %b err %0d expected 0000000 1", i, obs[15:9], obs[0]);
      else passes++;
      tick();
    end
    @(negedge clk);
    mem_req = 1; mem_ready = 0;
    #2;
    rst_n = 0;
    model_reset();
    #1;
    checks++;
    if (obs !== model_exp() || obs[8:0] !== 9'd0)
      $display("[TB] FAIL async_reset: got %b expected %b", obs[8:0], 9'd0);
    else passes++;
    @(negedge clk);
    rst_n = 1;
    tick();
  endtask

  task automatic test_random();
    logic [6:0] ops [7];
    ops = '{OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH, OP_NOP, 7'b1101111};
    do_reset();
    tick();
    for (int i = 0; i < 500; i++) begin
      if (m_err && $urandom_range(0, 3) == 0) begin
        do_reset();
        tick();
      end
      drive(ops[$urandom_range(0, 6)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 1)),
            (i < 250) ? ($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 1)));
      #1;
      checks++;
      if (obs !== model_exp())
        $display("[TB] FAIL random_%0d: got %b expected %b", i, obs, model_exp());
      else passes++;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    model_reset();
    test_reset();
    test_load_use();
    test_no_use();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
